// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral
//   Bus-mapped 8N1 UART transmitter with an 8-deep byte FIFO, a readable
//   status register and a "transmit drained" interrupt.
//
//   Register map (offsets from BASE_ADDR):
//     +0 TXDATA (write) push byte into the FIFO
//     +1 STATUS (read)  {count[3:0], overflow, busy, full, empty}
//     +2 CTRL   (write) [0] irq_en, [1] write-1 clears overflow
//               (read)  {7'b0, irq_en}
//
//   Ports:
//     CLK                  system clock, rising edge
//     RESET                synchronous, active-high reset
//     BUS_ADDR[7:0]        CPU bus address
//     BUS_DATA[7:0]        CPU bus data; driven only in the cycle after a read hit
//     BUS_WE               1 = write cycle, 0 = read cycle
//     BUS_INTERRUPT_RAISE  interrupt request, held until acknowledged
//     BUS_INTERRUPT_ACK    one-cycle acknowledge from the CPU
//     UART_TX              registered serial output, idle high
module uart_tx_peripheral #(
  parameter logic [7:0]  BASE_ADDR = 8'hE0,
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned FIFO_AW   = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic       UART_TX
);

  localparam int unsigned DIV   = CLK_HZ / BAUD;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [7:0]       A_TXDATA = BASE_ADDR;
  localparam logic [7:0]       A_STATUS = BASE_ADDR + 8'd1;
  localparam logic [7:0]       A_CTRL   = BASE_ADDR + 8'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               irq_q, irq_d;
  logic               irq_en_q;
  logic               ovf_q;

  logic [7:0]         fifo_mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  logic               rd_en_q;
  logic [7:0]         rd_data_q;

  logic               wr_tx, wr_ctrl, rd_hit;
  logic               push_ok, pop;
  logic               fifo_empty, fifo_full;
  logic               bit_end, stop_done;
  logic [3:0]         count4;
  logic [7:0]         status;

  // Bus decode and FIFO flags
  always_comb begin
    fifo_empty = (count_q == '0);
    // Count never exceeds DEPTH, so its MSB is set only when full.
    fifo_full  = count_q[FIFO_AW];
    wr_tx      = BUS_WE && (BUS_ADDR == A_TXDATA);
    wr_ctrl    = BUS_WE && (BUS_ADDR == A_CTRL);
    rd_hit     = !BUS_WE && ((BUS_ADDR == A_STATUS) || (BUS_ADDR == A_CTRL));
    // A push into a full FIFO still lands if the head leaves this cycle.
    push_ok    = wr_tx && (!fifo_full || pop);
    count4     = 4'(count_q);
    status     = {count4, ovf_q, (state_q != S_IDLE), fifo_full, fifo_empty};
  end

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    bit_end   = (cnt_q == CNT_MAX);

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. The line level is derived from the next state so the
  // registered UART_TX changes on the same edge as the state.
  always_comb begin
    tx_d      = 1'b1;
    stop_done = (state_q == S_STOP) && bit_end;
    irq_d     = irq_q;

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase

    if (BUS_INTERRUPT_ACK) begin
      irq_d = 1'b0;
    end
    // Setting has priority over a same-cycle acknowledge.
    if (stop_done && fifo_empty && irq_en_q) begin
      irq_d = 1'b1;
    end
  end

  // Control, FIFO pointers, interrupt and bus read pipeline
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      tx_q  <= tx_d;
      irq_q <= irq_d;

      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (wr_tx && !push_ok) begin
        ovf_q <= 1'b1;
      end else if (wr_ctrl && BUS_DATA[1]) begin
        ovf_q <= 1'b0;
      end
      if (wr_ctrl) begin
        irq_en_q <= BUS_DATA[0];
      end

      rd_en_q   <= rd_hit;
      rd_data_q <= (BUS_ADDR == A_STATUS) ? status : {7'b0, irq_en_q};
    end
  end

  // FIFO storage needs no reset; the pointers define its contents.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= BUS_DATA;
    end
  end

  assign BUS_DATA            = rd_en_q ? rd_data_q : 'z;
  assign UART_TX             = tx_q;
  assign BUS_INTERRUPT_RAISE = irq_q;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Testbench for uart_tx_peripheral with DIV = 10 (1 MHz clock, 100 kbaud).
// The bus carries a pull-up, so a released bus reads 8'hFF.
module tb_uart_tx_peripheral;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic       BUS_INTERRUPT_ACK = 1'b0;
  logic       BUS_INTERRUPT_RAISE;
  logic       UART_TX;
  wire  [7:0] BUS_DATA;

  logic [7:0] drv_data = 8'h00;
  logic       drv_en = 1'b0;

  assign BUS_DATA = drv_en ? drv_data : 'z;
  pullup (BUS_DATA);

  uart_tx_peripheral #(
    .BASE_ADDR(8'hE0),
    .CLK_HZ   (1_000_000),
    .BAUD     (100_000),
    .FIFO_AW  (3)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .BUS_ADDR           (BUS_ADDR),
    .BUS_DATA           (BUS_DATA),
    .BUS_WE             (BUS_WE),
    .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
    .BUS_INTERRUPT_ACK  (BUS_INTERRUPT_ACK),
    .UART_TX            (UART_TX)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b1;

  typedef struct {
    logic [7:0] d;
    int         c;
  } rd_t;

  logic [7:0] uart_q [$];
  rd_t        rd_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    BUS_WE   = 1'b1;
    drv_data = d;
    drv_en   = 1'b1;
    step();
    BUS_WE   = 1'b0;
    drv_en   = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  // Address cycle, then the data cycle; returns two cycles later.
  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp);
    rd_t e;
    e.d = exp;
    e.c = cyc + 1;
    rd_q.push_back(e);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    step();
    BUS_ADDR = 8'h00;
    step();
  endtask

  // Bus monitor: any DUT drive must match the oldest pending read.
  initial begin
    rd_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (!drv_en && BUS_DATA !== 8'hFF) begin
        if (rd_q.size() == 0) begin
          chk("bus_unexpected_drive", {24'h0, BUS_DATA}, 32'hFF);
        end else begin
          e = rd_q.pop_front();
          chk("bus_rd_cycle", cyc, e.c);
          chk("bus_rd_data", {24'h0, BUS_DATA}, {24'h0, e.d});
        end
      end
    end
  end

  // Serial monitor: decode each frame mid-bit and compare with the queue.
  initial begin
    logic [7:0] b;
    logic       st;
    logic       sp;
    logic [7:0] e;
    forever begin
      @(posedge CLK);
      #2;
      if (mon_en && !RESET && UART_TX === 1'b0) begin
        repeat (4) @(posedge CLK);
        #2;
        st = UART_TX;
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(posedge CLK);
          #2;
          b[i] = UART_TX;
        end
        repeat (10) @(posedge CLK);
        #2;
        sp = UART_TX;
        if (mon_en) begin
          chk("uart_start_bit", {31'h0, st}, 32'h0);
          chk("uart_stop_bit", {31'h0, sp}, 32'h1);
          if (uart_q.size() == 0) begin
            chk("uart_unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
          end else begin
            e = uart_q.pop_front();
            chk("uart_byte", {24'h0, b}, {24'h0, e});
          end
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion want completion (cycle %0d)", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [7:0] a5;
  logic       exp_bit;
  logic [7:0] tbl [10];
  int         t;
  int         lows;

  initial begin
    tbl = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h81, 8'h7E, 8'h0F, 8'hF0, 8'hC3, 8'h99};

    // Reset state
    RESET = 1'b1;
    step(3);
    RESET = 1'b0;
    chk("reset_tx", {31'h0, UART_TX}, 32'h1);
    chk("reset_irq", {31'h0, BUS_INTERRUPT_RAISE}, 32'h0);
    chk("reset_bus_released", {24'h0, BUS_DATA}, 32'hFF);

    // STATUS after reset, released on the address cycle and after the data cycle
    BUS_ADDR = 8'hE1;
    chk("rd_addr_cycle_released", {24'h0, BUS_DATA}, 32'hFF);
    bus_read(8'hE1, 8'h01);
    chk("rd_after_released", {24'h0, BUS_DATA}, 32'hFF);
    bus_read(8'hE2, 8'h00);

    // Single frame 0xA5, exact waveform and latency
    a5 = 8'hA5;
    uart_q.push_back(8'hA5);
    bus_write(8'hE0, 8'hA5);
    chk("lat_n1_idle", {31'h0, UART_TX}, 32'h1);
    for (int k = 0; k < 100; k++) begin
      step();
      if (k < 10)      exp_bit = 1'b0;
      else if (k < 90) exp_bit = a5[(k - 10) / 10];
      else             exp_bit = 1'b1;
      chk($sformatf("a5_wave_k%0d", k), {31'h0, UART_TX}, {31'h0, exp_bit});
    end
    step();
    chk("a5_idle_gap", {31'h0, UART_TX}, 32'h1);

    // Interrupt at end of stop bit, then acknowledge
    bus_write(8'hE2, 8'h01);
    bus_read(8'hE2, 8'h01);
    uart_q.push_back(8'h3C);
    bus_write(8'hE0, 8'h3C);
    step(100);
    chk("irq_before_stop_end", {31'h0, BUS_INTERRUPT_RAISE}, 32'h0);
    step();
    chk("irq_set", {31'h0, BUS_INTERRUPT_RAISE}, 32'h1);
    step(5);
    chk("irq_held", {31'h0, BUS_INTERRUPT_RAISE}, 32'h1);
    BUS_INTERRUPT_ACK = 1'b1;
    chk("irq_ack_cycle", {31'h0, BUS_INTERRUPT_RAISE}, 32'h1);
    step();
    BUS_INTERRUPT_ACK = 1'b0;
    chk("irq_cleared", {31'h0, BUS_INTERRUPT_RAISE}, 32'h0);
    bus_write(8'hE2, 8'h00);

    // Ten back-to-back writes: first pops, next eight fill, tenth drops
    for (int i = 0; i < 10; i++) begin
      if (i < 9) uart_q.push_back(tbl[i]);
      bus_write(8'hE0, tbl[i]);
    end
    bus_read(8'hE1, 8'h8E);
    t = 0;
    while (uart_q.size() != 0 && t < 3000) begin
      step();
      t++;
    end
    chk("drain_timeout", uart_q.size(), 0);
    step(10);
    bus_read(8'hE1, 8'h09);

    // Overflow clear via CTRL, irq_en follows bit 0
    bus_write(8'hE2, 8'h02);
    bus_read(8'hE1, 8'h01);
    bus_read(8'hE2, 8'h00);

    // Clearing irq_en leaves a pending interrupt raised
    bus_write(8'hE2, 8'h01);
    uart_q.push_back(8'h5A);
    bus_write(8'hE0, 8'h5A);
    t = 0;
    while (!BUS_INTERRUPT_RAISE && t < 300) begin
      step();
      t++;
    end
    chk("irq_wait", {31'h0, BUS_INTERRUPT_RAISE}, 32'h1);
    bus_write(8'hE2, 8'h00);
    chk("irq_kept_after_en_clear", {31'h0, BUS_INTERRUPT_RAISE}, 32'h1);
    step(3);
    chk("irq_still_kept", {31'h0, BUS_INTERRUPT_RAISE}, 32'h1);

    // Reset 45 cycles into a frame with 3 bytes queued
    mon_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_write(8'hE0, 8'hC0 + 8'(i));
    end
    step(43);
    chk("mid_frame_bit3", {31'h0, UART_TX}, 32'h0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("reset_abort_tx", {31'h0, UART_TX}, 32'h1);
    chk("reset_abort_irq", {31'h0, BUS_INTERRUPT_RAISE}, 32'h0);
    bus_read(8'hE1, 8'h01);
    lows = 0;
    repeat (300) begin
      step();
      if (UART_TX !== 1'b1) lows++;
    end
    chk("no_frames_after_reset", lows, 0);

    chk("rd_q_empty", rd_q.size(), 0);
    chk("uart_q_empty", uart_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
